// File: rtl/id_hazard_scoreboard.sv
// id_hazard_scoreboard: decode-stage issue controller. Tracks architectural
// registers with a write in flight between issue and writeback, and blocks
// issue on RAW, WAW or when the outstanding-write budget is exhausted.
module id_hazard_scoreboard #(
  parameter int MAX_OUT = 4,
  parameter int CNT_W   = 4,
  parameter int STALL_W = 16
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               id_valid,
  input  logic               rs1_r_ena,
  input  logic [4:0]         rs1_r_addr,
  input  logic               rs2_r_ena,
  input  logic [4:0]         rs2_r_addr,
  input  logic               rd_w_ena,
  input  logic [4:0]         rd_w_addr,
  input  logic               ex_ready,
  input  logic               wb_valid,
  input  logic [4:0]         wb_addr,
  input  logic               flush,
  output logic               issue,
  output logic               stall,
  output logic [31:0]        pending,
  output logic [CNT_W-1:0]   outstanding,
  output logic [STALL_W-1:0] stall_cycles
);

  logic [31:0]        pending_reg;
  logic [31:0]        pending_next;
  logic [CNT_W-1:0]   outstanding_reg;
  logic [CNT_W-1:0]   outstanding_next;
  logic [STALL_W-1:0] stall_cycles_reg;
  logic [STALL_W-1:0] stall_cycles_next;

  logic wr_eff;
  logic raw;
  logic waw;
  logic full;
  logic ret;
  logic set_en;

  // Hazard detection against the registered mask only (no writeback bypass)
  always_comb begin
    wr_eff = rd_w_ena & (rd_w_addr != 5'd0);
    raw    = (rs1_r_ena & pending_reg[rs1_r_addr]) |
             (rs2_r_ena & pending_reg[rs2_r_addr]);
    waw    = wr_eff & pending_reg[rd_w_addr];
    full   = wr_eff & (outstanding_reg == CNT_W'(MAX_OUT));
    stall  = id_valid & (raw | waw | full);
    issue  = id_valid & ~stall & ex_ready & ~flush;
    ret    = wb_valid & (wb_addr != 5'd0) & pending_reg[wb_addr];
    set_en = issue & wr_eff;
  end

  // x0 is never tracked
  assign pending_next[0] = 1'b0;

  // Per-register pending bit: flush clears, issue sets, retire clears (set wins)
  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_pend
      always_comb begin
        pending_next[gi] = pending_reg[gi];
        if (flush) begin
          pending_next[gi] = 1'b0;
        end else if (set_en && (rd_w_addr == 5'(gi))) begin
          pending_next[gi] = 1'b1;
        end else if (ret && (wb_addr == 5'(gi))) begin
          pending_next[gi] = 1'b0;
        end
      end
    end
  endgenerate

  // Outstanding counter follows the pending mask: +1 on tracked issue, -1 on retire
  always_comb begin
    outstanding_next = outstanding_reg;
    if (flush) begin
      outstanding_next = '0;
    end else begin
      case ({set_en, ret})
        2'b10:   outstanding_next = outstanding_reg + CNT_W'(1);
        2'b01:   outstanding_next = outstanding_reg - CNT_W'(1);
        default: outstanding_next = outstanding_reg;
      endcase
    end
  end

  // Saturating count of cycles where a valid instruction failed to issue
  always_comb begin
    stall_cycles_next = stall_cycles_reg;
    if (id_valid && !issue && !flush && !(&stall_cycles_reg)) begin
      stall_cycles_next = stall_cycles_reg + STALL_W'(1);
    end
  end

  // State registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      pending_reg      <= '0;
      outstanding_reg  <= '0;
      stall_cycles_reg <= '0;
    end else begin
      pending_reg      <= pending_next;
      outstanding_reg  <= outstanding_next;
      stall_cycles_reg <= stall_cycles_next;
    end
  end

  assign pending      = pending_reg;
  assign outstanding  = outstanding_reg;
  assign stall_cycles = stall_cycles_reg;

endmodule

// File: tb/tb_id_hazard_scoreboard.sv
// Directed table-driven bench for id_hazard_scoreboard.
module tb_id_hazard_scoreboard;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic        rs1_r_ena;
  logic [4:0]  rs1_r_addr;
  logic        rs2_r_ena;
  logic [4:0]  rs2_r_addr;
  logic        rd_w_ena;
  logic [4:0]  rd_w_addr;
  logic        ex_ready;
  logic        wb_valid;
  logic [4:0]  wb_addr;
  logic        flush;
  logic        issue;
  logic        stall;
  logic [31:0] pending;
  logic [3:0]  outstanding;
  logic [15:0] stall_cycles;

  int checks;
  int failures;

  id_hazard_scoreboard #(.MAX_OUT(4), .CNT_W(4), .STALL_W(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid),
    .rs1_r_ena(rs1_r_ena), .rs1_r_addr(rs1_r_addr),
    .rs2_r_ena(rs2_r_ena), .rs2_r_addr(rs2_r_addr),
    .rd_w_ena(rd_w_ena), .rd_w_addr(rd_w_addr),
    .ex_ready(ex_ready), .wb_valid(wb_valid), .wb_addr(wb_addr),
    .flush(flush), .issue(issue), .stall(stall), .pending(pending),
    .outstanding(outstanding), .stall_cycles(stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic        rst, idv, r1e;
    logic [4:0]  r1a;
    logic        r2e;
    logic [4:0]  r2a;
    logic        we;
    logic [4:0]  wa;
    logic        exr, wbv;
    logic [4:0]  wba;
    logic        fl;
    logic        e_iss, e_st;
    logic [31:0] e_pend;
    logic [3:0]  e_out;
    logic [15:0] e_sc;
  } vec_t;

  localparam int NV = 27;
  vec_t vecs [NV];

  function automatic vec_t mk(logic r, logic iv, logic a1e, logic [4:0] a1,
                              logic a2e, logic [4:0] a2, logic w, logic [4:0] wad,
                              logic er, logic bv, logic [4:0] ba, logic f,
                              logic ei, logic es, logic [31:0] ep,
                              logic [3:0] eo, logic [15:0] esc);
    vec_t v;
    v.rst = r; v.idv = iv; v.r1e = a1e; v.r1a = a1; v.r2e = a2e; v.r2a = a2;
    v.we = w; v.wa = wad; v.exr = er; v.wbv = bv; v.wba = ba; v.fl = f;
    v.e_iss = ei; v.e_st = es; v.e_pend = ep; v.e_out = eo; v.e_sc = esc;
    return v;
  endfunction

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
    end
  endtask

  task automatic drive(vec_t v);
    rst = v.rst; id_valid = v.idv; rs1_r_ena = v.r1e; rs1_r_addr = v.r1a;
    rs2_r_ena = v.r2e; rs2_r_addr = v.r2a; rd_w_ena = v.we; rd_w_addr = v.wa;
    ex_ready = v.exr; wb_valid = v.wbv; wb_addr = v.wba; flush = v.fl;
  endtask

  // Apply one vector: check combinational outputs mid-cycle, then registered state after the edge
  task automatic run_vec(int idx, vec_t v);
    @(negedge clk);
    drive(v);
    #1;
    chk($sformatf("v%0d.issue", idx), 32'(issue), 32'(v.e_iss));
    chk($sformatf("v%0d.stall", idx), 32'(stall), 32'(v.e_st));
    @(posedge clk);
    #1;
    chk($sformatf("v%0d.pending", idx), pending, v.e_pend);
    chk($sformatf("v%0d.outstanding", idx), 32'(outstanding), 32'(v.e_out));
    chk($sformatf("v%0d.stall_cycles", idx), 32'(stall_cycles), 32'(v.e_sc));
    chk($sformatf("v%0d.popcount", idx), 32'(outstanding), 32'($countones(pending)));
    $display("vec %0d: issue=%0b stall=%0b pending=0x%08h outstanding=%0d stall_cycles=%0d",
             idx, issue, stall, pending, outstanding, stall_cycles);
  endtask

  initial begin
    checks = 0;
    failures = 0;
    drive(mk(1,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));

    //            rst idv r1e r1a r2e r2a we wa exr wbv wba fl  iss st pend      out sc
    vecs[0]  = mk(1, 0, 0, 0,  0, 0,  0, 0,  0, 0, 0, 0,  0, 0, 32'h0,    0, 0);
    vecs[1]  = mk(0, 1, 0, 0,  0, 0,  1, 5,  1, 0, 0, 0,  1, 0, 32'h20,   1, 0);
    vecs[2]  = mk(0, 1, 1, 5,  0, 0,  0, 0,  1, 0, 0, 0,  0, 1, 32'h20,   1, 1);
    vecs[3]  = mk(0, 1, 1, 5,  0, 0,  0, 0,  1, 1, 5, 0,  0, 1, 32'h0,    0, 2);
    vecs[4]  = mk(0, 1, 1, 5,  0, 0,  0, 0,  1, 0, 0, 0,  1, 0, 32'h0,    0, 2);
    vecs[5]  = mk(0, 1, 0, 0,  0, 0,  1, 1,  1, 0, 0, 0,  1, 0, 32'h2,    1, 2);
    vecs[6]  = mk(0, 1, 0, 0,  0, 0,  1, 2,  1, 0, 0, 0,  1, 0, 32'h6,    2, 2);
    vecs[7]  = mk(0, 1, 0, 0,  0, 0,  1, 3,  1, 0, 0, 0,  1, 0, 32'hE,    3, 2);
    vecs[8]  = mk(0, 1, 0, 0,  0, 0,  1, 4,  1, 0, 0, 0,  1, 0, 32'h1E,   4, 2);
    vecs[9]  = mk(0, 1, 0, 0,  0, 0,  1, 6,  1, 0, 0, 0,  0, 1, 32'h1E,   4, 3);
    vecs[10] = mk(0, 1, 0, 0,  0, 0,  0, 6,  1, 0, 0, 0,  1, 0, 32'h1E,   4, 3);
    vecs[11] = mk(0, 0, 0, 0,  0, 0,  0, 0,  0, 1, 1, 0,  0, 0, 32'h1C,   3, 3);
    vecs[12] = mk(0, 1, 0, 0,  0, 0,  1, 7,  1, 1, 3, 0,  1, 0, 32'h94,   3, 3);
    vecs[13] = mk(0, 1, 1, 0,  0, 0,  1, 0,  1, 0, 0, 0,  1, 0, 32'h94,   3, 3);
    vecs[14] = mk(0, 0, 0, 0,  0, 0,  0, 0,  0, 1, 9, 0,  0, 0, 32'h94,   3, 3);
    vecs[15] = mk(0, 1, 0, 0,  0, 0,  1, 8,  0, 0, 0, 0,  0, 0, 32'h94,   3, 4);
    vecs[16] = mk(0, 0, 0, 0,  0, 0,  0, 0,  0, 1, 2, 0,  0, 0, 32'h90,   2, 4);
    vecs[17] = mk(0, 1, 0, 0,  0, 0,  1, 5,  1, 0, 0, 0,  1, 0, 32'hB0,   3, 4);
    vecs[18] = mk(0, 1, 0, 0,  0, 0,  1, 6,  1, 0, 0, 0,  1, 0, 32'hF0,   4, 4);
    vecs[19] = mk(0, 1, 0, 0,  0, 0,  0, 0,  1, 1, 4, 1,  0, 0, 32'h0,    0, 4);
    vecs[20] = mk(0, 1, 0, 0,  0, 0,  1, 9,  1, 0, 0, 0,  1, 0, 32'h200,  1, 4);
    vecs[21] = mk(1, 1, 0, 0,  0, 0,  1, 10, 1, 0, 0, 0,  1, 0, 32'h0,    0, 0);
    vecs[22] = mk(0, 1, 1, 9,  0, 0,  0, 0,  1, 0, 0, 0,  1, 0, 32'h0,    0, 0);
    vecs[23] = mk(0, 1, 0, 0,  0, 0,  1, 11, 1, 0, 0, 0,  1, 0, 32'h800,  1, 0);
    vecs[24] = mk(0, 1, 0, 11, 1, 11, 0, 0,  1, 0, 0, 0,  0, 1, 32'h800,  1, 1);
    vecs[25] = mk(0, 1, 0, 0,  0, 0,  1, 11, 1, 0, 0, 0,  0, 1, 32'h800,  1, 2);
    vecs[26] = mk(0, 1, 0, 0,  0, 0,  1, 11, 1, 0, 0, 1,  0, 1, 32'h0,    0, 2);

    for (int i = 0; i < NV; i++) begin
      run_vec(i, vecs[i]);
    end

    // Backpressure: ex_ready low for three cycles, each counted, then the write issues
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      drive(mk(0,1,0,0,0,0,1,12,0,0,0,0, 0,0,0,0,0));
      #1;
      chk($sformatf("bp%0d.issue", k), 32'(issue), 32'd0);
      @(posedge clk);
      #1;
      chk($sformatf("bp%0d.stall_cycles", k), 32'(stall_cycles), 32'(3 + k));
      $display("bp %0d: issue=%0b stall_cycles=%0d", k, issue, stall_cycles);
    end
    @(negedge clk);
    ex_ready = 1'b1;
    #1;
    chk("bp_release.issue", 32'(issue), 32'd1);
    @(posedge clk);
    #1;
    chk("bp_release.pending", pending, 32'h1000);
    chk("bp_release.stall_cycles", 32'(stall_cycles), 32'd5);
    $display("bp release: pending=0x%08h outstanding=%0d stall_cycles=%0d",
             pending, outstanding, stall_cycles);

    @(negedge clk);
    drive(mk(0,0,0,0,0,0,0,0,0,0,0,0, 0,0,0,0,0));
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/id_hazard_scoreboard.md
Name: id_hazard_scoreboard

Overview:
- Issue controller for the decode stage. It tracks which architectural registers have a write in flight between decode and writeback.
- It gates instruction issue from decode into execute: stalls on RAW hazards, WAW hazards and outstanding-write capacity; issues otherwise.
- It sits between the decode-stage register-enable/address outputs and the execute/writeback stages. It clears on writeback and on pipeline flush.

Parameters:
- MAX_OUT, 4, maximum number of in-flight register writes (1..15).
- CNT_W, 4, width of the outstanding-write counter; must satisfy 2^CNT_W > MAX_OUT.
- STALL_W, 16, width of the saturating stall-cycle counter.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- rst  in  1  synchronous, active-high reset.
- id_valid  in  1  decode holds a valid instruction.
- rs1_r_ena  in  1  instruction reads rs1.
- rs1_r_addr  in  5  rs1 index.
- rs2_r_ena  in  1  instruction reads rs2.
- rs2_r_addr  in  5  rs2 index.
- rd_w_ena  in  1  instruction writes rd.
- rd_w_addr  in  5  rd index.
- ex_ready  in  1  execute stage can accept an instruction this cycle.
- wb_valid  in  1  writeback retires a register write this cycle.
- wb_addr  in  5  register index being retired.
- flush  in  1  pipeline flush; discards all in-flight writes.
- issue  out  1  instruction transfers to execute this cycle (combinational).
- stall  out  1  hazard or capacity block (combinational).
- pending  out  32  registered per-register pending mask; bit 0 always 0.
- outstanding  out  CNT_W  registered count of in-flight writes.
- stall_cycles  out  STALL_W  registered saturating count of blocked cycles.

Behaviour:
- Reset: on a clk edge with rst=1, pending=0, outstanding=0, stall_cycles=0. Combinational outputs still evaluate while rst=1, but every state update is suppressed.
- Effective write: wr_eff = rd_w_ena & (rd_w_addr != 0). Register x0 is never tracked. Reads of x0 never hazard.
- raw = (rs1_r_ena & pending[rs1_r_addr]) | (rs2_r_ena & pending[rs2_r_addr]). Disabled read ports are ignored regardless of address.
- waw = wr_eff & pending[rd_w_addr].
- full = wr_eff & (outstanding == MAX_OUT).
- stall = id_valid & (raw | waw | full). When id_valid=0, stall=0.
- issue = id_valid & ~stall & ex_ready & ~flush.
- Hazard checks use the registered pending mask only; there is no same-cycle writeback bypass. A dependent instruction issues at the earliest one cycle after the cycle in which its producer's wb_valid is seen.
- Retire: ret = wb_valid & (wb_addr != 0) & pending[wb_addr]. A writeback to a non-pending register or to x0 is ignored: no count change, no error.
- Next state when flush=0:
  - pending[wb_addr] is cleared if ret.
  - pending[rd_w_addr] is set if issue & wr_eff. Set wins if both target the same index.
  - outstanding += (issue & wr_eff) - ret. Issue and retire in the same cycle leave the count unchanged.
- Flush (rst=0, flush=1): next pending=0 and outstanding=0. Issue is forced to 0 in the flush cycle. A writeback arriving in the same cycle is absorbed. stall_cycles is not affected by flush.
- stall_cycles increments by 1 on each cycle with id_valid & ~issue & ~flush, covering both hazard stalls and ex_ready backpressure. It saturates at all-ones and never wraps.
- Invariant: outstanding == popcount(pending) at all times. The verification bench asserts this every cycle.
- Decode holds its instruction stable while id_valid & ~issue. This block does not register the instruction.

Test Plan:
- Reset, then id_valid=1, rd_w_addr=5, rd_w_ena=1, ex_ready=1 -> issue=1 in that cycle; next cycle pending=0x0000_0020, outstanding=1.
- With x5 pending, present rs1_r_ena=1, rs1_r_addr=5 -> stall=1, issue=0. Assert wb_valid, wb_addr=5 -> stall still 1 that cycle. Next cycle stall=0, issue=1, pending bit5=0. stall_cycles increments across the blocked cycles.
- Issue writes to x1, x2, x3, x4 back-to-back (MAX_OUT=4) -> outstanding=4. A fifth instruction writing x6 gives stall=1 (full). The same instruction with rd_w_ena=0 and no read hazards gives issue=1.
- Issue a write to x7 in the same cycle as wb_valid for x3 -> outstanding unchanged; pending gains bit7 and loses bit3.
- Instruction with rd_w_addr=0, rd_w_ena=1 -> issue=1; pending and outstanding unchanged. A wb_valid with wb_addr=9 while x9 is not pending -> no change.
- With pending=0x0000_00F0, outstanding=4, assert flush together with id_valid=1 -> issue=0. Next cycle pending=0, outstanding=0. Assert rst mid-stream -> all registered outputs read 0 the following cycle.
